// File: rtl/dll_ctrl_pkg.sv
// Shared types for the FMDLL delay-code controller: loop states, window
// decisions and the vote accumulator sizing rule.
package dll_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    HOLD,
    UP,
    DN
  } dec_t;

  // Accumulator must hold +/-FILT_LEN as a signed value.
  function automatic int acc_width(input int filt_len);
    return $clog2(filt_len) + 2;
  endfunction

endpackage

// File: rtl/pd_vote_filter.sv
// Majority filter for phase-detector pulses: SETTLE ignored cycles, then
// FILT_LEN signed votes, then a one-cycle decision strobe.
module pd_vote_filter
  import dll_ctrl_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int SETTLE   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic pd_up,
  input  logic pd_dn,
  output logic dec_valid,
  output dec_t decision
);

  localparam int ACC_W = acc_width(FILT_LEN);
  localparam int LAST  = SETTLE + FILT_LEN - 1;
  localparam int CNT_W = $clog2(SETTLE + FILT_LEN + 1);

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] vote;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    sampling;
  logic                    last_cycle;

  // The final sample is folded in combinationally so the decision is
  // available in the same cycle as that sample.
  always_comb begin
    vote = '0;
    if (pd_up && !pd_dn) begin
      vote = ACC_W'(1);
    end else if (pd_dn && !pd_up) begin
      vote = '1;
    end
    sampling   = (cnt >= CNT_W'(SETTLE));
    last_cycle = (cnt == CNT_W'(LAST));
    acc_sum    = sampling ? (acc + vote) : acc;
    dec_valid  = active && last_cycle;
    decision   = HOLD;
    if (acc_sum > 0) begin
      decision = UP;
    end else if (acc_sum < 0) begin
      decision = DN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (!active || last_cycle) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/dll_code_controller.sv
// Closed-loop delay-code controller: coarse acquisition, unit-step tracking
// and lock detection driving the 10-bit FMDLL delay code.
module dll_code_controller
  import dll_ctrl_pkg::*;
#(
  parameter int CODE_W      = 10,
  parameter int INIT_CODE   = 512,
  parameter int FILT_LEN    = 8,
  parameter int SETTLE      = 4,
  parameter int COARSE_STEP = 16,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pd_up,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] q,
  output logic              q_upd,
  output logic              locked,
  output logic              code_sat
);

  localparam int LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam int UNLOCK_W = $clog2(UNLOCK_CNT + 1);

  state_t state, state_n;
  dec_t   prev_dir, prev_dir_n;
  dec_t   dec;
  logic   dec_valid;

  logic [CODE_W-1:0]   q_n;
  logic [CODE_W-1:0]   cand;
  logic                q_upd_n, locked_n, code_sat_n;
  logic                clamp, reversal, acq_exit;
  logic [CODE_W:0]     step_sz, sum_up, sum_dn;
  logic [LOCK_W-1:0]   lock_cnt, lock_cnt_n;
  logic [UNLOCK_W-1:0] unlock_cnt, unlock_cnt_n;

  pd_vote_filter #(
    .FILT_LEN(FILT_LEN),
    .SETTLE  (SETTLE)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .active   (en && (state != IDLE)),
    .pd_up    (pd_up),
    .pd_dn    (pd_dn),
    .dec_valid(dec_valid),
    .decision (dec)
  );

  // The reversal/HOLD that ends acquisition is already a tracking decision:
  // it takes a unit step and counts as the first lock event.
  always_comb begin
    reversal = (dec != HOLD) && (prev_dir != HOLD) && (dec != prev_dir);
    acq_exit = (state == ACQUIRE) && ((dec == HOLD) || reversal);
    step_sz  = ((state == ACQUIRE) && !acq_exit) ? (CODE_W+1)'(COARSE_STEP) : (CODE_W+1)'(1);
    sum_up   = {1'b0, q} + step_sz;
    sum_dn   = {1'b0, q} - step_sz;
    cand     = q;
    clamp    = 1'b0;
    case (dec)
      UP: begin
        clamp = sum_up[CODE_W];
        cand  = clamp ? '1 : sum_up[CODE_W-1:0];
      end
      DN: begin
        clamp = sum_dn[CODE_W];
        cand  = clamp ? '0 : sum_dn[CODE_W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n      = state;
    prev_dir_n   = prev_dir;
    q_n          = q;
    q_upd_n      = 1'b0;
    locked_n     = locked;
    code_sat_n   = code_sat;
    lock_cnt_n   = lock_cnt;
    unlock_cnt_n = unlock_cnt;
    if (!en) begin
      state_n      = IDLE;
      locked_n     = 1'b0;
      lock_cnt_n   = '0;
      unlock_cnt_n = '0;
    end else if (state == IDLE) begin
      state_n      = ACQUIRE;
      q_n          = CODE_W'(INIT_CODE);
      prev_dir_n   = HOLD;
      lock_cnt_n   = '0;
      unlock_cnt_n = '0;
    end else if (dec_valid) begin
      q_n        = cand;
      q_upd_n    = (cand != q);
      code_sat_n = clamp;
      if (dec != HOLD) begin
        prev_dir_n = dec;
      end
      case (state)
        ACQUIRE: begin
          if (acq_exit) begin
            state_n    = TRACK;
            lock_cnt_n = LOCK_W'(1);
          end
        end
        TRACK: begin
          if ((dec == HOLD) || reversal) begin
            if (lock_cnt == LOCK_W'(LOCK_CNT - 1)) begin
              state_n      = LOCKED;
              locked_n     = 1'b1;
              lock_cnt_n   = '0;
              unlock_cnt_n = '0;
            end else begin
              lock_cnt_n = lock_cnt + LOCK_W'(1);
            end
          end else begin
            lock_cnt_n = '0;
          end
        end
        LOCKED: begin
          if ((dec != HOLD) && !reversal) begin
            if (unlock_cnt == UNLOCK_W'(UNLOCK_CNT - 1)) begin
              state_n      = TRACK;
              locked_n     = 1'b0;
              lock_cnt_n   = '0;
              unlock_cnt_n = '0;
            end else begin
              unlock_cnt_n = unlock_cnt + UNLOCK_W'(1);
            end
          end else begin
            unlock_cnt_n = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_dir   <= HOLD;
      q          <= CODE_W'(INIT_CODE);
      q_upd      <= 1'b0;
      locked     <= 1'b0;
      code_sat   <= 1'b0;
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else begin
      state      <= state_n;
      prev_dir   <= prev_dir_n;
      q          <= q_n;
      q_upd      <= q_upd_n;
      locked     <= locked_n;
      code_sat   <= code_sat_n;
      lock_cnt   <= lock_cnt_n;
      unlock_cnt <= unlock_cnt_n;
    end
  end

endmodule
